last_round: RTL and testbench

Final AES-128 encryption round: SubBytes, ShiftRows, and AddRoundKey with an on-the-fly expanded round key. It is the stage after round 9 of the cipher datapath. It takes the round-9 state and the round-9 key, computes the round-10 key itself, and registers the ciphertext. The whole computation is combinational, followed by one output register stage.

---
 rtl/aes_pkg.sv | 55 +++++
 rtl/key_gen.sv | 38 +++
 rtl/shift_row.sv | 26 ++
 rtl/sub_bytes.sv | 22 ++
 rtl/last_round.sv | 59 +++++
 tb/tb_last_round.sv | 157 +++++++++++++++
 6 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES-128 types, forward S-box table and Rcon lookup.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] state_t;

    localparam logic [7:0] C_SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return C_SBOX[b];
    endfunction

    // Indices outside 1..10 deliberately map to zero rather than wrapping.
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] v;
        case (idx)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_gen.sv
`default_nettype none
// ============================================================================
// Module      : key_gen
// Description : One step of the AES-128 key schedule (combinational).
// Revision    : 1.0 - initial release
// ============================================================================
module key_gen
    import aes_pkg::*;
(
    input  logic [3:0]   rc,
    input  logic [127:0] key_in,
    output logic [127:0] key_out
);

    word_t w_w0, w_w1, w_w2, w_w3;
    word_t w_rot, w_sub, w_t;
    word_t w_w4, w_w5, w_w6, w_w7;

    assign {w_w0, w_w1, w_w2, w_w3} = key_in;
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_subword
            assign w_sub[8*i +: 8] = sbox(w_rot[8*i +: 8]);
        end
    endgenerate

    assign w_t  = w_sub ^ {rcon(rc), 24'h0};
    assign w_w4 = w_w0 ^ w_t;
    assign w_w5 = w_w4 ^ w_w1;
    assign w_w6 = w_w5 ^ w_w2;
    assign w_w7 = w_w6 ^ w_w3;

    assign key_out = {w_w4, w_w5, w_w6, w_w7};

endmodule
`default_nettype wire

// File: rtl/shift_row.sv
`default_nettype none
// ============================================================================
// Module      : shift_row
// Description : AES ShiftRows; row r rotates left by r byte positions.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_row
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    output logic [127:0] state_out
);

    // Byte k = row k%4, column k/4, stored MSB-first at [127-8k -: 8].
    genvar r, c;
    generate
        for (c = 0; c < 4; c++) begin : g_col
            for (r = 0; r < 4; r++) begin : g_row
                assign state_out[127 - 8*(r + 4*c) -: 8] =
                    state_in[127 - 8*(r + 4*((c + r) % 4)) -: 8];
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/sub_bytes.sv
`default_nettype none
// ============================================================================
// Module      : sub_bytes
// Description : Forward S-box applied to all 16 state bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module sub_bytes
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    output logic [127:0] state_out
);

    genvar k;
    generate
        for (k = 0; k < 16; k++) begin : g_byte
            assign state_out[8*k +: 8] = sbox(state_in[8*k +: 8]);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/last_round.sv
`default_nettype none
// ============================================================================
// Module      : last_round
// Description : AES-128 round 10 (SubBytes, ShiftRows, AddRoundKey) with
//               on-the-fly key expansion and one output register stage.
// Revision    : 1.0 - initial release
// ============================================================================
module last_round
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [3:0]   rc,
    input  logic [127:0] round_in,
    input  logic [127:0] last_key_in,
    output logic [127:0] final_out,
    output logic         out_valid
);

    state_t w_sub;
    state_t w_shift;
    state_t w_key;
    state_t r_final;
    logic   r_out_valid;

    key_gen u_key_gen (
        .rc      (rc),
        .key_in  (last_key_in),
        .key_out (w_key)
    );

    sub_bytes u_sub_bytes (
        .state_in  (round_in),
        .state_out (w_sub)
    );

    shift_row u_shift_row (
        .state_in  (w_sub),
        .state_out (w_shift)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_final     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_final <= w_key ^ w_shift;
            end
        end
    end

    assign final_out = r_final;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_last_round.sv
`default_nettype none
// ============================================================================
// Module      : tb_last_round
// Description : Directed self-checking bench for last_round.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_last_round;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [3:0]   rc;
    logic [127:0] round_in;
    logic [127:0] last_key_in;
    logic [127:0] final_out;
    logic         out_valid;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] C_B_IN   = 128'heb40f21e592e38848ba113e71bc342d2;
    localparam logic [127:0] C_B_KEY  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] C_B_OUT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C_B_SUB  = 128'he9098972cb31075f3d327d94af2e2cb5;
    localparam logic [127:0] C_B_SHF  = 128'he9317db5cb322c723d2e895faf090794;
    localparam logic [127:0] C_B_RKEY = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] C_Z_OUT  = {4{32'h01000000}};
    // 0x52 maps to 0x00 through the S-box, so final_out exposes the round key.
    localparam logic [127:0] C_PASS   = {16{8'h52}};

    always #5 clk = ~clk;

    last_round dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .rc          (rc),
        .round_in    (round_in),
        .last_key_in (last_key_in),
        .final_out   (final_out),
        .out_valid   (out_valid)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] r,
                         input logic [127:0] s, input logic [127:0] k);
        @(negedge clk);
        in_valid    = v;
        rc          = r;
        round_in    = s;
        last_key_in = k;
    endtask

    task automatic step(input logic v, input logic [3:0] r,
                        input logic [127:0] s, input logic [127:0] k);
        drive(v, r, s, k);
        @(posedge clk);
        #1;
    endtask

    logic [7:0] rcon_exp [1:10];

    initial begin
        rcon_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        rc          = 4'd0;
        round_in    = '0;
        last_key_in = '0;

        #12;
        check("reset_final", final_out, 128'h0);
        check("reset_valid", {127'h0, out_valid}, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // FIPS-197 Appendix B round 10
        step(1'b1, 4'd10, C_B_IN, C_B_KEY);
        check("appb_final", final_out, C_B_OUT);
        check("appb_valid", {127'h0, out_valid}, 128'h1);
        check("appb_sub",   dut.w_sub,   C_B_SUB);
        check("appb_shift", dut.w_shift, C_B_SHF);
        check("appb_key",   dut.w_key,   C_B_RKEY);

        step(1'b1, 4'd1, 128'h0, 128'h0);
        check("zero_final", final_out, C_Z_OUT);
        check("zero_key", dut.w_key, {4{32'h62636363}});

        step(1'b1, 4'd1, C_PASS, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        check("keypath", final_out, 128'ha0fafe1788542cb123a339392a6c7605);

        // Out-of-range rc contributes no Rcon
        step(1'b1, 4'd0, 128'h0, 128'h0);
        check("rc0_final", final_out, 128'h0);
        step(1'b1, 4'd0, C_PASS, 128'h0);
        check("rc0_key", final_out, {4{32'h63636363}});
        step(1'b1, 4'd15, 128'h0, 128'h0);
        check("rc15_final", final_out, 128'h0);
        step(1'b1, 4'd15, C_PASS, 128'h0);
        check("rc15_key", final_out, {4{32'h63636363}});
        step(1'b1, 4'd11, 128'h0, 128'h0);
        check("rc11_final", final_out, 128'h0);

        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 4'(i), 128'h0, 128'h0);
            check($sformatf("rcon_%0d", i), final_out, {4{rcon_exp[i], 24'h0}});
        end

        // Back-to-back then hold
        step(1'b1, 4'd10, C_B_IN, C_B_KEY);
        check("b2b_first", final_out, C_B_OUT);
        step(1'b1, 4'd1, 128'h0, 128'h0);
        check("b2b_second", final_out, C_Z_OUT);
        check("b2b_valid", {127'h0, out_valid}, 128'h1);
        step(1'b0, 4'd10, C_B_IN, C_B_KEY);
        check("hold_final", final_out, C_Z_OUT);
        check("hold_valid", {127'h0, out_valid}, 128'h0);
        step(1'b0, 4'd3, C_PASS, C_B_KEY);
        check("hold2_final", final_out, C_Z_OUT);

        // Asynchronous reset between edges
        step(1'b1, 4'd10, C_B_IN, C_B_KEY);
        check("pre_rst_final", final_out, C_B_OUT);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_final", final_out, 128'h0);
        check("async_rst_valid", {127'h0, out_valid}, 128'h0);
        step(1'b1, 4'd1, 128'h0, 128'h0);
        check("in_rst_final", final_out, 128'h0);
        check("in_rst_valid", {127'h0, out_valid}, 128'h0);
        @(negedge clk);
        rst_n    = 1'b1;
        rc       = 4'd10;
        round_in = C_B_IN;
        last_key_in = C_B_KEY;
        @(posedge clk);
        #1;
        check("post_rst_final", final_out, C_B_OUT);
        check("post_rst_valid", {127'h0, out_valid}, 128'h1);
        step(1'b1, 4'd1, 128'h0, 128'h0);
        check("post_rst_next", final_out, C_Z_OUT);

        step(1'b0, 4'd0, 128'h0, 128'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
